mem_core_requester: RTL

//  Core-side initiator for the line-wide memory request/response interface. Accepts word loads/stores

---
 rtl/mem_core_requester_pkg.sv | 46 ++++
 rtl/mem_core_requester_if.sv | 39 +++
 rtl/mem_line_merge.sv | 29 ++
 rtl/mem_core_requester.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_core_requester_pkg.sv
// Shared types, sizes and address helpers for the core-side line memory requester.
// Contents: state_t (IDLE/RD/WR/RESP), geometry localparams (WPL, OFF_W, LINE_AW, ...),
// and helpers line_of/off_of (split a word address) and word_of (pick a word out of a line).
// LINE_WIDTH, BYTE_WIDTH and MEM_SIZE normally come from the codebase defines; the fallbacks
// below give a 128-bit line, 8-bit byte, 256-line memory.

`ifndef LINE_WIDTH
`define LINE_WIDTH 128
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 4096
`endif

package mem_requester_pkg;

  localparam int unsigned LINE_WIDTH = `LINE_WIDTH;
  localparam int unsigned BYTE_W     = `BYTE_WIDTH;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned NUM_LINES  = `MEM_SIZE / (`LINE_WIDTH / `BYTE_WIDTH);
  localparam int unsigned LINE_AW    = $clog2(NUM_LINES);
  localparam int unsigned WPL        = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned OFF_W      = $clog2(WPL);
  localparam int unsigned ADDR_W     = LINE_AW + OFF_W;
  localparam int unsigned BE_W       = WORD_WIDTH / BYTE_W;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  function automatic logic [LINE_AW-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFF_W];
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W-1:0];
  endfunction

  function automatic logic [WORD_WIDTH-1:0] word_of(input logic [LINE_WIDTH-1:0] line,
                                                    input logic [OFF_W-1:0]      off);
    int unsigned base;
    base = 32'(off) * WORD_WIDTH;
    return line[base +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/mem_core_requester_if.sv
// Bundle of the LSU-side request/response handshake and the line memory request/response bus.
// modport master: the requester's view (takes LSU requests, drives memory requests).
// modport slave : the environment's view (LSU plus line memory).

interface mem_core_requester_if;
  import mem_requester_pkg::*;

  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic                  cpu_req_write;
  logic [ADDR_W-1:0]     cpu_req_addr;
  logic [WORD_WIDTH-1:0] cpu_req_wdata;
  logic [BE_W-1:0]       cpu_req_be;
  logic                  cpu_rsp_valid;
  logic                  cpu_rsp_ready;
  logic [WORD_WIDTH-1:0] cpu_rsp_rdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [LINE_AW-1:0]    mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [LINE_AW-1:0]    mem_raddr;
  logic [LINE_WIDTH-1:0] mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    input  cpu_rsp_ready, mem_rvalid, mem_raddr, mem_rdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata, cpu_req_be,
    output cpu_rsp_ready, mem_rvalid, mem_raddr, mem_rdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_line_merge.sv
// Combinational byte merge of one store word into a memory line.
// Ports: i_line   line as read from memory
//        i_word   store data
//        i_offset word slot within the line
//        i_be     byte enables for i_word
//        o_line   i_line with the enabled bytes of slot i_offset replaced

module mem_line_merge
  import mem_requester_pkg::*;
(
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic [WORD_WIDTH-1:0] i_word,
  input  logic [OFF_W-1:0]      i_offset,
  input  logic [BE_W-1:0]       i_be,
  output logic [LINE_WIDTH-1:0] o_line
);

  always_comb begin
    int unsigned base;
    o_line = i_line;
    base   = 32'(i_offset) * WORD_WIDTH;
    for (int b = 0; b < BE_W; b++) begin
      if (i_be[b]) begin
        o_line[base + b * BYTE_W +: BYTE_W] = i_word[b * BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/mem_core_requester.sv
// Core-side initiator between the MEM stage LSU and the line memory. One word load/store in
// flight: loads read the line and return the addressed word; stores read the line, byte-merge
// the word and write the line back. Memory reads are combinational, writes commit at the edge.
// Ports: clock, reset (synchronous, active-low); io_bus (mem_core_requester_if.master) carrying
//        cpu_req_*/cpu_rsp_* towards the LSU and mem_* towards the line memory.
// Build option MEM_REQ_LINE_BUF_EN: adds a one-entry line buffer; an accept that hits it skips
// the memory read (load straight to RESP, store straight to WR).

module mem_core_requester
  import mem_requester_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  mem_core_requester_if.master io_bus
);

  state_t r_state, w_state_next;

  logic                  r_write;
  logic [ADDR_W-1:0]     r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]       r_be;
  logic [LINE_WIDTH-1:0] r_line;
  logic [WORD_WIDTH-1:0] r_rdata;

  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_hit;
  logic [LINE_AW-1:0]    w_line;
  logic [OFF_W-1:0]      w_off;
  logic [LINE_WIDTH-1:0] w_merged;
  logic [LINE_WIDTH-1:0] w_hit_line;
  logic [WORD_WIDTH-1:0] w_hit_word;

  assign w_line      = line_of(r_addr);
  assign w_off       = off_of(r_addr);
  assign w_req_ready = (r_state == IDLE);
  assign w_accept    = io_bus.cpu_req_valid && w_req_ready;
  // A response for some other line is ignored; we keep reading until ours shows up.
  assign w_capture   = (r_state == RD) && io_bus.mem_rvalid && (io_bus.mem_raddr == w_line);

  mem_line_merge u_merge (
    .i_line   (r_line),
    .i_word   (r_wdata),
    .i_offset (w_off),
    .i_be     (r_be),
    .o_line   (w_merged)
  );

`ifdef MEM_REQ_LINE_BUF_EN
  logic                  r_buf_valid;
  logic [LINE_AW-1:0]    r_buf_tag;
  logic [LINE_WIDTH-1:0] r_buf_line;

  assign w_hit      = r_buf_valid && (r_buf_tag == line_of(io_bus.cpu_req_addr));
  assign w_hit_line = r_buf_line;

  // Tracks the last line read or written so it always mirrors memory for its tag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_line  <= '0;
    end else if (w_capture) begin
      r_buf_valid <= 1'b1;
      r_buf_tag   <= w_line;
      r_buf_line  <= io_bus.mem_rdata;
    end else if (r_state == WR) begin
      r_buf_valid <= 1'b1;
      r_buf_tag   <= w_line;
      r_buf_line  <= w_merged;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_line = '0;
`endif

  assign w_hit_word = word_of(w_hit_line, off_of(io_bus.cpu_req_addr));

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_state_next = io_bus.cpu_req_write ? WR : RESP;
          end else begin
            w_state_next = RD;
          end
        end
      end
      RD: begin
        if (w_capture) begin
          w_state_next = r_write ? WR : RESP;
        end
      end
      WR:   w_state_next = RESP;
      RESP: begin
        if (io_bus.cpu_rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs; held at zero while reset is asserted so an interrupted WR never reaches memory.
  always_comb begin
    io_bus.cpu_req_ready = 1'b0;
    io_bus.cpu_rsp_valid = 1'b0;
    io_bus.cpu_rsp_rdata = '0;
    io_bus.mem_read      = 1'b0;
    io_bus.mem_write     = 1'b0;
    io_bus.mem_addr      = '0;
    io_bus.mem_wdata     = '0;
    if (reset) begin
      unique case (r_state)
        IDLE: io_bus.cpu_req_ready = 1'b1;
        RD: begin
          io_bus.mem_read = 1'b1;
          io_bus.mem_addr = w_line;
        end
        WR: begin
          io_bus.mem_write = 1'b1;
          io_bus.mem_addr  = w_line;
          io_bus.mem_wdata = w_merged;
        end
        RESP: begin
          io_bus.cpu_rsp_valid = 1'b1;
          io_bus.cpu_rsp_rdata = r_rdata;
        end
        default: ;
      endcase
    end
  end

  // Request latch and captured line / response word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_line  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= io_bus.cpu_req_write;
        r_addr  <= io_bus.cpu_req_addr;
        r_wdata <= io_bus.cpu_req_wdata;
        r_be    <= io_bus.cpu_req_be;
        if (w_hit) begin
          r_line  <= w_hit_line;
          r_rdata <= io_bus.cpu_req_write ? '0 : w_hit_word;
        end
      end
      if (w_capture) begin
        r_line  <= io_bus.mem_rdata;
        r_rdata <= r_write ? '0 : word_of(io_bus.mem_rdata, w_off);
      end
    end
  end

endmodule
